// File: rtl/prbs_bert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_bert_ctrl
//  Purpose  : Bit-error-rate test controller for a PRBS loopback. Seeds the
//             transmit generator, self-synchronises a receive checker to the
//             incoming stream (d[n] = d[n-7] ^ d[n-10]), then counts bit
//             errors over a programmed number of received bits.
//  Ports    : clk, rst (async, active-low)
//             start / abort          - test control
//             frame_len              - bits to measure, captured on start
//             rx_data / rx_valid     - received bit and its qualifier
//             gen_rst_n / gen_en     - transmit generator reset / enable
//             busy / locked / done   - state decodes
//             timeout                - test ended without achieving lock
//             err_cnt / bit_cnt      - measurement results
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_bert_ctrl #(
    parameter int LEN_W        = 16,
    parameter int ERR_W        = 16,
    parameter int SYNC_BITS    = 10,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             rx_data,
    input  logic             rx_valid,
    output logic             gen_rst_n,
    output logic             gen_en,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [LEN_W-1:0] bit_cnt
);

    localparam int c_MATCH_W = $clog2(SYNC_BITS + 1);
    localparam int c_SYNC_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [c_MATCH_W-1:0] c_SYNC_BITS    = c_MATCH_W'(SYNC_BITS);
    localparam logic [c_SYNC_W-1:0]  c_SYNC_TIMEOUT = c_SYNC_W'(SYNC_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_SYNC    = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_seed_cnt;
    logic                  r_gen_rst_n;
    logic                  r_timeout;
    logic [LEN_W-1:0]      r_frame_len;
    logic [ERR_W-1:0]      r_err_cnt;
    logic [LEN_W-1:0]      r_bit_cnt;
    logic [9:0]            r_hist;      // r_hist[k] = bit received k+1 valid cycles ago
    logic [c_MATCH_W-1:0]  r_match;
    logic [c_SYNC_W-1:0]   r_sync_cnt;

    logic                  w_pred;
    logic                  w_accept;
    logic                  w_sync_upd;
    logic                  w_meas_upd;
    logic [c_MATCH_W-1:0]  w_match_inc;
    logic [c_SYNC_W-1:0]   w_sync_inc;
    logic [LEN_W-1:0]      w_bit_inc;

    assign w_pred      = r_hist[6] ^ r_hist[9];
    assign w_match_inc = r_match + 1'b1;
    assign w_sync_inc  = r_sync_cnt + 1'b1;
    assign w_bit_inc   = r_bit_cnt + 1'b1;

    // Counters freeze on abort so the partial result stays readable in IDLE.
    assign w_sync_upd  = (r_state == S_SYNC) && rx_valid && !abort;
    assign w_meas_upd  = (r_state == S_MEASURE) && rx_valid && !abort &&
                         (r_frame_len != '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and state decodes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        gen_en      = 1'b0;
        busy        = 1'b0;
        locked      = 1'b0;
        done        = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_SEED;
                        w_accept    = 1'b1;
                    end
                end
                S_SEED: begin
                    if (r_seed_cnt) begin
                        w_state_nxt = S_SYNC;
                    end
                end
                S_SYNC: begin
                    // Lock on the same bit as the timeout wins.
                    if (rx_valid) begin
                        if ((rx_data == w_pred) && (w_match_inc == c_SYNC_BITS)) begin
                            w_state_nxt = S_MEASURE;
                        end else if (w_sync_inc == c_SYNC_TIMEOUT) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_MEASURE: begin
                    if (r_frame_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (rx_valid && (w_bit_inc == r_frame_len)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        gen_en = (r_state == S_SYNC) || (r_state == S_MEASURE);
        busy   = (r_state == S_SEED) || (r_state == S_SYNC) || (r_state == S_MEASURE);
        locked = (r_state == S_MEASURE);
        done   = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------------
    // Datapath: seed timer, generator reset, checker and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seed_cnt  <= 1'b0;
            r_gen_rst_n <= 1'b0;
            r_timeout   <= 1'b0;
            r_frame_len <= '0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_hist      <= '0;
            r_match     <= '0;
            r_sync_cnt  <= '0;
        end else begin
            // Registered from next state so the generator reset lines up
            // exactly with the SEED cycles and stays low while rst is low.
            r_gen_rst_n <= (w_state_nxt != S_SEED);
            r_seed_cnt  <= (r_state == S_SEED) && !r_seed_cnt;

            if (w_accept) begin
                r_frame_len <= frame_len;
                r_err_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_timeout   <= 1'b0;
                r_hist      <= '0;
                r_match     <= '0;
                r_sync_cnt  <= '0;
            end else begin
                if (w_sync_upd) begin
                    r_hist     <= {r_hist[8:0], rx_data};
                    r_match    <= (rx_data == w_pred) ? w_match_inc : '0;
                    r_sync_cnt <= w_sync_inc;
                    if (w_state_nxt == S_DONE) begin
                        r_timeout <= 1'b1;
                    end
                end
                if (w_meas_upd) begin
                    // Once locked the checker runs on its own prediction so a
                    // received error is counted once and never propagates.
                    r_hist    <= {r_hist[8:0], w_pred};
                    r_bit_cnt <= w_bit_inc;
                    if ((rx_data != w_pred) && !(&r_err_cnt)) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign gen_rst_n = r_gen_rst_n;
    assign timeout   = r_timeout;
    assign err_cnt   = r_err_cnt;
    assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_bert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_bert_ctrl
//  Purpose  : Self-checking bench for prbs_bert_ctrl. A reference stream obeys
//             d[n] = d[n-7] ^ d[n-10]; lock point, bit and error counts are
//             derived from that stream and the injected inversions.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prbs_bert_ctrl;

    localparam int LEN_W        = 16;
    localparam int ERR_W        = 4;
    localparam int SYNC_BITS    = 10;
    localparam int SYNC_TIMEOUT = 4096;
    localparam int ERR_MAX      = (1 << ERR_W) - 1;
    localparam int STRM_LEN     = 6200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             rx_data = 1'b0;
    logic             rx_valid = 1'b0;
    logic             gen_rst_n, gen_en, busy, locked, done, timeout;
    logic [ERR_W-1:0] err_cnt;
    logic [LEN_W-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    bit strm[$];
    int inj_q[$];

    always #5 clk = ~clk;

    prbs_bert_ctrl #(
        .LEN_W(LEN_W), .ERR_W(ERR_W), .SYNC_BITS(SYNC_BITS), .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .gen_rst_n(gen_rst_n), .gen_en(gen_en),
        .busy(busy), .locked(locked), .done(done), .timeout(timeout),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > ERR_MAX) ? ERR_MAX : n;
    endfunction

    function automatic bit in_inj(input int k);
        foreach (inj_q[i]) if (inj_q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    // pat 0: recurrence stream from a random non-zero seed; 1: all 0; 2: all 1
    task automatic build_stream(input int pat);
        logic [9:0] seed;
        strm.delete();
        seed = 10'($urandom_range(1, 1023));
        for (int n = 0; n < STRM_LEN; n++) begin
            if (pat == 1)      strm.push_back(1'b0);
            else if (pat == 2) strm.push_back(1'b1);
            else if (n < 10)   strm.push_back(seed[n]);
            else               strm.push_back(strm[n-7] ^ strm[n-10]);
        end
    endtask

    // Number of received bits needed to lock, or -1 for a sync timeout.
    function automatic int model_lock();
        int  run_len = 0;
        bit  p;
        for (int n = 0; n < SYNC_TIMEOUT; n++) begin
            p = ((n >= 7) ? strm[n-7] : 1'b0) ^ ((n >= 10) ? strm[n-10] : 1'b0);
            run_len = (strm[n] == p) ? run_len + 1 : 0;
            if (run_len == SYNC_BITS) return n + 1;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gen_rst_n"}, gen_rst_n, 0);
        chk({tag, "_gen_en"},    gen_en,    0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_locked"},    locked,    0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_timeout"},   timeout,   0);
        chk({tag, "_err_cnt"},   err_cnt,   0);
        chk({tag, "_bit_cnt"},   bit_cnt,   0);
    endtask

    // vmode 0: valid always; 1: every other cycle; 2: random
    task automatic run(input int flen, input int pat, input int vmode,
                       input int abort_at, input bit start_in_sync);
        int L, n_sent, nerr, seed_cycles, cyc;
        bit seen_lock, fin, ms, b;
        n_sent = 0; nerr = 0; seed_cycles = 0; cyc = 0;
        seen_lock = 0; fin = 0; ms = 0;
        build_stream(pat);
        L = model_lock();

        frame_len = LEN_W'(flen);
        start = 1'b1;
        tick();
        start = 1'b0;
        frame_len = LEN_W'($urandom);   // captured value must be used, not this
        chk("start_bit_cnt", bit_cnt, 0);
        chk("start_err_cnt", err_cnt, 0);
        chk("start_timeout", timeout, 0);
        chk("start_busy",    busy,    1);
        while (gen_rst_n === 1'b0 && seed_cycles < 10) begin
            seed_cycles++;
            chk("seed_gen_en", gen_en, 0);
            tick();
        end
        chk("seed_len", seed_cycles, 2);

        while (!fin && cyc < 20000) begin
            if (abort_at >= 0 && locked && (n_sent - L) == abort_at) begin
                abort = 1'b1;
                rx_valid = 1'b1;
                rx_data = 1'($urandom_range(0, 1));
                tick();
                abort = 1'b0;
                chk("abort_busy",    busy,    0);
                chk("abort_locked",  locked,  0);
                chk("abort_done",    done,    0);
                chk("abort_gen_en",  gen_en,  0);
                chk("abort_bit_cnt", bit_cnt, abort_at);
                chk("abort_err_cnt", err_cnt, sat(nerr));
                tick();
                chk("abort_hold_bit_cnt", bit_cnt, abort_at);
                rx_valid = 1'b0;
                return;
            end
            rx_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            rx_data  = 1'($urandom_range(0, 1));
            if (rx_valid && gen_en) begin
                b = strm[n_sent];
                if (L >= 0 && n_sent >= L && in_inj(n_sent - L)) begin
                    b = !b;
                    nerr++;
                end
                rx_data = b;
                n_sent++;
            end
            if (start_in_sync && !ms && gen_en && !locked) begin
                start = 1'b1;
                ms = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (locked && !seen_lock) begin
                seen_lock = 1'b1;
                chk("lock_point", n_sent, L);
            end
            if (locked) begin
                chk("meas_bit_cnt", bit_cnt, n_sent - L);
                chk("meas_err_cnt", err_cnt, sat(nerr));
                chk("meas_gen_rst_n", gen_rst_n, 1);
            end
            if (done) fin = 1'b1;
        end
        rx_valid = 1'b0;
        chk("reached_done", fin, 1);
        chk("done_busy",    busy,   0);
        chk("done_locked",  locked, 0);
        chk("done_gen_en",  gen_en, 0);
        chk("done_gen_rst_n", gen_rst_n, 1);
        if (L < 0) begin
            chk("to_timeout",  timeout, 1);
            chk("to_bits",     n_sent,  SYNC_TIMEOUT);
            chk("to_bit_cnt",  bit_cnt, 0);
            chk("to_err_cnt",  err_cnt, 0);
            chk("to_no_lock",  seen_lock, 0);
        end else begin
            chk("done_timeout", timeout, 0);
            chk("done_bit_cnt", bit_cnt, flen);
            chk("done_err_cnt", err_cnt, sat(nerr));
            if (flen > 0) chk("done_bits_sent", n_sent, L + flen);
        end
        tick();
        chk("done_hold", done, 1);
        chk("done_hold_bit_cnt", bit_cnt, (L < 0) ? 0 : flen);
    endtask

    initial begin
        int w;
        // Reset asserted asynchronously, before any clock edge
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_async");
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check_reset_vals("rst_held");
        rst = 1'b1;
        tick();
        chk("rel_gen_rst_n", gen_rst_n, 1);
        chk("rel_busy", busy, 0);

        // abort and start together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_gen_rst_n", gen_rst_n, 1);

        inj_q.delete();
        run(1000, 0, 0, -1, 1'b0);               // clean loopback
        inj_q = '{100, 500, 900};
        run(1000, 0, 0, -1, 1'b1);               // three inversions, start ignored in SYNC
        inj_q.delete();
        run(200, 1, 0, -1, 1'b0);                // constant 0 locks
        run(50, 2, 0, -1, 1'b0);                 // constant 1 times out
        run(64, 0, 1, -1, 1'b0);                 // valid every other cycle
        run(0, 0, 2, -1, 1'b0);                  // zero-length frame
        run(300, 0, 0, 50, 1'b0);                // abort at measured bit 50
        run(100, 0, 2, -1, 1'b0);                // restart after abort
        for (int i = 0; i < 30; i++) inj_q.push_back(i);
        run(60, 0, 2, -1, 1'b0);                 // error counter saturation
        for (int r = 0; r < 3; r++) begin
            inj_q.delete();
            for (int k = 0; k < 4; k++) inj_q.push_back($urandom_range(0, 150));
            run($urandom_range(1, 150), 0, 2, -1, 1'b0);
        end

        // Asynchronous reset pulse mid-SYNC, between clock edges
        inj_q.delete();
        frame_len = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!gen_en && w < 10) begin
            tick();
            w++;
        end
        chk("pre_rst_in_sync", gen_en, 1);
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 1'($urandom_range(0, 1));
            tick();
        end
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_mid_sync");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_data = 1'($urandom_range(0, 1));
            tick();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
        end
        rx_valid = 1'b0;

        run(50, 0, 0, -1, 1'b0);                 // normal test after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
